// File: rtl/ssp_pkg.sv
// Shared types and helpers for the SSP transmit scheduler
// and the receive-side distributor.
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_MAX  = 8;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] idx;
        logic       found;
        logic [7:0] sh;
        int         j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < n) begin
                j  = (int'(ptr) + k) % n;
                sh = req >> j;
                if (sh[0] && !found) begin
                    idx   = 3'(j);
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ssp_rr_arb.sv
// Combinational round-robin picker, shared by the transmit
// scheduler and the receive-side distributor.
module ssp_rr_arb
    import ssp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [2:0]      idx,
    output logic            any
);

    logic [7:0] req_ext;

    assign req_ext = 8'(req);
    assign idx     = rr_pick(req_ext, ptr, NREQ);
    assign any     = |req;

endmodule

// File: rtl/ssp_tx_sched.sv
// SSP transmit scheduler: round-robin with burst cap onto the talker TX FIFO.
// Build option SSP_TX_PRIO_EN makes requester 0 high priority and uncapped.
module ssp_tx_sched
    import ssp_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAXBURST = 4
) (
    input  logic                  pclk,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      txdata,
    output logic                  txwrite,
    input  logic                  txfull,
    output logic [2:0]            grant_id,
    output logic                  busy
);

    localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);
    localparam logic [3:0] CAP      = 4'(MAXBURST - 1);

    state_t     state, state_nx;
    logic [2:0] owner, owner_nx;
    logic [2:0] ptr, ptr_nx;
    logic [3:0] cnt, cnt_nx;

    logic [7:0]       req_ext;
    logic [7:0]       last_ext;
    logic [WIDTH-1:0] words [8];

    logic [2:0] arb_idx;
    logic       arb_any;
    logic [2:0] pick;
    logic [2:0] ptr_after;
    logic       own_req;
    logic       own_last;
    logic       accept;
    logic       at_cap;
    logic       keep_ptr;

    assign req_ext  = 8'(req);
    assign last_ext = 8'(req_last);

    for (genvar g = 0; g < 8; g++) begin : g_words
        if (g < NREQ) begin : g_on
            assign words[g] = req_data[g*WIDTH +: WIDTH];
        end else begin : g_off
            assign words[g] = '0;
        end
    end

    ssp_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign own_req   = req_ext[owner];
    assign own_last  = last_ext[owner];
    assign accept    = (state == XFER) && own_req && !txfull;
    assign ptr_after = (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;

`ifdef SSP_TX_PRIO_EN
    assign pick     = req[0] ? 3'd0 : arb_idx;
    assign at_cap   = (cnt == CAP) && (owner != 3'd0);
    assign keep_ptr = (owner == 3'd0);
`else
    assign pick     = arb_idx;
    assign at_cap   = (cnt == CAP);
    assign keep_ptr = 1'b0;
`endif

    // State, owner, rotation pointer and burst count registers.
    always_ff @(posedge pclk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    // Arbitration in IDLE; burst progress and release in XFER.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    owner_nx = pick;
                    cnt_nx   = '0;
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    if (own_last || at_cap) begin
                        state_nx = IDLE;
                        ptr_nx   = keep_ptr ? ptr : ptr_after;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end else if (!own_req) begin
                    state_nx = IDLE;
                    ptr_nx   = keep_ptr ? ptr : ptr_after;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write-port outputs follow the owner's handshake directly.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = accept && (owner == 3'(i));
        end
        txwrite  = accept;
        txdata   = (state == XFER) ? words[owner] : '0;
        grant_id = owner;
        busy     = (state == XFER);
    end

endmodule

// File: tb/tb_ssp_tx_sched.sv
// Self-checking bench for ssp_tx_sched: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_ssp_tx_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MB   = 4;

    logic         pclk = 1'b0;
    logic         clear;
    logic [3:0]   req;
    logic [31:0]  req_data;
    logic [3:0]   req_last;
    logic [3:0]   ack;
    logic [7:0]   txdata;
    logic         txwrite;
    logic         txfull;
    logic [2:0]   grant_id;
    logic         busy;

    always #5 pclk = ~pclk;

    ssp_tx_sched #(
        .NREQ     (NREQ),
        .WIDTH    (W),
        .MAXBURST (MB)
    ) dut (
        .pclk     (pclk),
        .clear    (clear),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .txdata   (txdata),
        .txwrite  (txwrite),
        .txfull   (txfull),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Requester queues feeding the DUT
    logic [7:0] qd [4][$];
    bit         ql [4][$];
    logic [3:0] ack_n = '0;

    // Write log captured from the FIFO port
    int         lg_own [$];
    logic [7:0] lg_dat [$];
    int         lg_cyc [$];
    int         cyc = 0;

    int         exp_o [$];
    logic [7:0] exp_d [$];

    // Spec-level model: words sent per burst, release rules, rotation
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int pick;
    bit cap_on;

    function automatic void m_release();
        m_busy = 1'b0;
`ifdef SSP_TX_PRIO_EN
        if (m_owner != 0)
`endif
        m_ptr = (m_owner + 1) % NREQ;
    endfunction

    always @(posedge pclk or posedge clear) begin
        if (clear) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (!m_busy) begin
            if (req != 4'b0) begin
                pick = -1;
`ifdef SSP_TX_PRIO_EN
                if (req[0]) pick = 0;
`endif
                for (int k = 0; k < NREQ; k++)
                    if (pick < 0 && req[(m_ptr + k) % NREQ])
                        pick = (m_ptr + k) % NREQ;
                m_owner = pick;
                m_cnt   = 0;
                m_busy  = 1'b1;
            end
        end else begin
            cap_on = 1'b1;
`ifdef SSP_TX_PRIO_EN
            if (m_owner == 0) cap_on = 1'b0;
`endif
            if (req[m_owner] && !txfull) begin
                m_cnt++;
                if (req_last[m_owner] || (cap_on && m_cnt == MB))
                    m_release();
            end else if (!req[m_owner]) begin
                m_release();
            end
        end
    end

    // Compare process: every cycle outside reset
    bit acc_m;
    always @(negedge pclk) begin
        ack_n = ack;
        cyc++;
        if (!clear) begin
            acc_m = m_busy && req[m_owner] && !txfull;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("grant_id", 32'(grant_id), 32'(m_owner));
            chk("txwrite", 32'(txwrite), 32'(acc_m));
            chk("ack", 32'(ack), acc_m ? (32'd1 << m_owner) : 32'd0);
            chk("txdata", 32'(txdata),
                m_busy ? 32'(req_data[m_owner*8 +: 8]) : 32'd0);
        end
        if (txwrite) begin
            lg_own.push_back(int'(grant_id));
            lg_dat.push_back(txdata);
            lg_cyc.push_back(cyc);
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (qd[i].size() > 0) begin
                req[i]             = 1'b1;
                req_data[i*8 +: 8] = qd[i][0];
                req_last[i]        = ql[i][0];
            end else begin
                req[i]             = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_n[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        ack_n = '0;
        drive();
    endtask

    task automatic push(int i, logic [7:0] d, bit l);
        qd[i].push_back(d);
        ql[i].push_back(l);
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (qd[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(string nm);
        int n = 0;
        while ((!all_empty() || busy) && n < 300) begin
            step();
            n++;
        end
        chk(nm, 32'(all_empty() && !busy), 32'd1);
    endtask

    task automatic wait_owner(int g, string nm);
        int n = 0;
        while (!(busy && grant_id == 3'(g)) && n < 50) begin
            step();
            n++;
        end
        chk(nm, 32'(busy && grant_id == 3'(g)), 32'd1);
    endtask

    task automatic clr_log();
        lg_own.delete();
        lg_dat.delete();
        lg_cyc.delete();
        exp_o.delete();
        exp_d.delete();
    endtask

    task automatic chk_log(string nm);
        int n;
        chk({nm, "_len"}, 32'(lg_dat.size()), 32'(exp_d.size()));
        n = (lg_dat.size() < exp_d.size()) ? lg_dat.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_own"}, 32'(lg_own[i]), 32'(exp_o[i]));
            chk({nm, "_dat"}, 32'(lg_dat[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        txfull   = 1'b0;
        step();
        step();
        @(negedge pclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txwrite", 32'(txwrite), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_txdata", 32'(txdata), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        step();
        clear = 1'b0;

        // Reset during owner 1's burst; ptr must restart at 0
        for (int k = 0; k < 5; k++) push(0, 8'(8'h01 + k), k == 4);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b1);
        push(3, 8'h31, 1'b1);
        drive();
        wait_owner(1, "rst_reach_owner1");
        clear = 1'b1;
        @(negedge pclk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_txwrite", 32'(txwrite), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_gid", 32'(grant_id), 32'd0);
        step();
        clear = 1'b0;
        step();
        @(negedge pclk);
        chk("rst_regrant_busy", 32'(busy), 32'd1);
        chk("rst_regrant_gid", 32'(grant_id), 32'd0);
        drain("rst_drain");

        // Single requester, one-word packet
        clr_log();
        push(2, 8'hA5, 1'b1);
        drive();
        step();
        @(negedge pclk);
        chk("single_txwrite", 32'(txwrite), 32'd1);
        chk("single_txdata", 32'(txdata), 32'hA5);
        chk("single_ack", 32'(ack), 32'b0100);
        chk("single_gid", 32'(grant_id), 32'd2);
        step();
        push(1, 8'h1B, 1'b1);
        push(3, 8'h3B, 1'b1);
        drive();
        step();
        @(negedge pclk);
        chk("single_ptr3_gid", 32'(grant_id), 32'd3);
        drain("single_drain");

        // Withdrawal by owner 3 and wrap to requester 0
        push(3, 8'h77, 1'b0);
        txfull = 1'b1;
        drive();
        step();
        @(negedge pclk);
        chk("wd_gid", 32'(grant_id), 32'd3);
        chk("wd_stall", 32'(txwrite), 32'd0);
        step();
        qd[3].delete();
        ql[3].delete();
        drive();
        step();
        txfull = 1'b0;
        clr_log();
        push(0, 8'h80, 1'b1);
        push(3, 8'h90, 1'b1);
        drive();
        step();
        @(negedge pclk);
        chk("wrap_gid", 32'(grant_id), 32'd0);
        drain("wrap_drain");
        exp_o = '{0, 3};
        exp_d = '{8'h80, 8'h90};
        chk_log("wrap_log");

        // Burst cap with a second requester pending
        clr_log();
        for (int k = 0; k < 6; k++) push(0, 8'(8'hA0 + k), 1'b0);
        push(1, 8'hB0, 1'b0);
        push(1, 8'hB1, 1'b1);
        drive();
        drain("burst_drain");
        exp_o = '{0, 0, 0, 0, 1, 1, 0, 0};
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
        chk_log("burst_log");
        if (lg_cyc.size() == 8)
            chk("burst_span", 32'(lg_cyc[7] - lg_cyc[0] + 1), 32'd10);

        // Back-pressure for three cycles mid-burst
        clr_log();
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b0);
        push(2, 8'h44, 1'b1);
        drive();
        step();
        step();
        txfull = 1'b1;
        @(negedge pclk);
        chk("bp_txwrite", 32'(txwrite), 32'd0);
        chk("bp_ack", 32'(ack), 32'd0);
        chk("bp_hold", 32'(txdata), 32'h22);
        step();
        step();
        step();
        txfull = 1'b0;
        drain("bp_drain");
        exp_o = '{2, 2, 2, 2};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk_log("bp_log");
        if (lg_cyc.size() == 4)
            chk("bp_span", 32'(lg_cyc[3] - lg_cyc[0] + 1), 32'd7);

`ifdef SSP_TX_PRIO_EN
        // Requester 0 preempts rotation and ignores the burst cap
        push(0, 8'h5A, 1'b1);
        drive();
        drain("prio_pre_drain");
        clr_log();
        push(1, 8'hC0, 1'b0);
        push(1, 8'hC1, 1'b1);
        push(2, 8'hD0, 1'b1);
        push(3, 8'hE0, 1'b1);
        drive();
        wait_owner(1, "prio_owner1");
        for (int k = 0; k < 6; k++) push(0, 8'(8'hF0 + k), k == 5);
        drive();
        drain("prio_drain");
        exp_o = '{1, 1, 0, 0, 0, 0, 0, 0, 2, 3};
        exp_d = '{8'hC0, 8'hC1, 8'hF0, 8'hF1, 8'hF2, 8'hF3,
                  8'hF4, 8'hF5, 8'hD0, 8'hE0};
        chk_log("prio_log");
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
